// File: rtl/wb_ram_init_mux.sv
// Wishbone stage that fills a RAM region with a constant word after reset, then passes the SoC master through.
// Define WB_RAM_INIT_MUX_STREAM_EN to add a streamed preload (LOAD) phase fed by the ld_* port.
module wb_ram_init_mux #(
    parameter int          AW          = 32,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          CLEAR_WORDS = 1024,
    parameter logic [31:0] FILL_WORD   = 32'h0000_0000,
    parameter int          TIMEOUT     = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,

    input  logic [AW-1:0] m_adr_i,
    input  logic [31:0]   m_dat_i,
    input  logic [3:0]    m_sel_i,
    input  logic          m_we_i,
    input  logic          m_cyc_i,
    input  logic          m_stb_i,
    input  logic [2:0]    m_cti_i,
    input  logic [1:0]    m_bte_i,
    output logic [31:0]   m_dat_o,
    output logic          m_ack_o,
    output logic          m_err_o,

    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,

`ifdef WB_RAM_INIT_MUX_STREAM_EN
    input  logic          ld_valid_i,
    input  logic [31:0]   ld_data_i,
    input  logic          ld_last_i,
    output logic          ld_ready_o,
`endif

    output logic          init_done_o,
    output logic          init_err_o
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_CLEAR,
`ifdef WB_RAM_INIT_MUX_STREAM_EN
        ST_LOAD,
`endif
        ST_HANDOVER,
        ST_PASS
    } state_e;

    localparam logic [31:0]   LAST_IDX = (CLEAR_WORDS > 0) ? 32'(CLEAR_WORDS - 1) : 32'd0;
    localparam logic [31:0]   TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam logic [AW-1:0] BASE     = AW'(BASE_ADR);

    state_e        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   idx_q, idx_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
`ifdef WB_RAM_INIT_MUX_STREAM_EN
    logic          last_q, last_d;
`endif

    logic          wr_end;
    logic          wr_bad;
    logic [AW-1:0] word_adr;

    // An outstanding init write ends on ack, err or timeout; err wins over a simultaneous ack.
    assign wr_end   = cyc_q && (s_ack_i || s_err_i || (tmo_q >= TMO_LAST));
    assign wr_bad   = cyc_q && (s_err_i || (!s_ack_i && (tmo_q >= TMO_LAST)));
    assign word_adr = BASE + AW'({idx_q, 2'b00});

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        done_d  = done_q;
`ifdef WB_RAM_INIT_MUX_STREAM_EN
        last_d  = last_q;
`endif

        // Dropping cyc here guarantees an idle cycle before the next write starts.
        if (cyc_q) begin
            if (wr_end) begin
                cyc_d = 1'b0;
                tmo_d = '0;
                idx_d = idx_q + 32'd1;
                if (wr_bad) begin
                    err_d = 1'b1;
                end
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end

        case (state_q)
            ST_RESET: begin
                if (CLEAR_WORDS > 0) begin
                    state_d = ST_CLEAR;
                end else begin
`ifdef WB_RAM_INIT_MUX_STREAM_EN
                    state_d = ST_LOAD;
`else
                    state_d = ST_HANDOVER;
`endif
                end
            end
            ST_CLEAR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    adr_d = word_adr;
                    dat_d = FILL_WORD;
                    tmo_d = '0;
                end else if (wr_end && (idx_q == LAST_IDX)) begin
                    idx_d = '0;
`ifdef WB_RAM_INIT_MUX_STREAM_EN
                    state_d = ST_LOAD;
`else
                    state_d = ST_HANDOVER;
`endif
                end
            end
`ifdef WB_RAM_INIT_MUX_STREAM_EN
            ST_LOAD: begin
                if (!cyc_q && ld_valid_i) begin
                    cyc_d  = 1'b1;
                    adr_d  = word_adr;
                    dat_d  = ld_data_i;
                    tmo_d  = '0;
                    last_d = ld_last_i;
                end else if (wr_end && last_q) begin
                    state_d = ST_HANDOVER;
                end
            end
`endif
            // Switch only between master cycles so no transfer is split across owners.
            ST_HANDOVER: begin
                if (!m_cyc_i) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                end
            end
            ST_PASS: begin
                state_d = ST_PASS;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_RESET;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef WB_RAM_INIT_MUX_STREAM_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef WB_RAM_INIT_MUX_STREAM_EN
            last_q  <= last_d;
`endif
        end
    end

    // Before PASS the master is stalled and the RAM only sees the init engine.
    always_comb begin
        if (state_q == ST_PASS) begin
            s_adr_o = m_adr_i;
            s_dat_o = m_dat_i;
            s_sel_o = m_sel_i;
            s_we_o  = m_we_i;
            s_cyc_o = m_cyc_i;
            s_stb_o = m_stb_i;
            s_cti_o = m_cti_i;
            s_bte_o = m_bte_i;
            m_dat_o = s_dat_i;
            m_ack_o = s_ack_i;
            m_err_o = s_err_i;
        end else begin
            s_adr_o = adr_q;
            s_dat_o = dat_q;
            s_sel_o = cyc_q ? 4'hF : 4'h0;
            s_we_o  = cyc_q;
            s_cyc_o = cyc_q;
            s_stb_o = cyc_q;
            s_cti_o = 3'b000;
            s_bte_o = 2'b00;
            m_dat_o = '0;
            m_ack_o = 1'b0;
            m_err_o = 1'b0;
        end
    end

`ifdef WB_RAM_INIT_MUX_STREAM_EN
    assign ld_ready_o = (state_q == ST_LOAD) && !cyc_q;
`endif

    assign init_done_o = done_q;
    assign init_err_o  = err_q;

endmodule
